// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that grants one set/reset operation at a time into an SR flag bank
// and keeps a registered shadow copy of the flag states.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAG-1:0]     s_out,
  output logic [NFLAG-1:0]     r_out,
  output logic [NFLAG-1:0]     q,
  output logic                 busy,
  output logic                 err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW:0] NF = (IDXW+1)'(NFLAG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   w_q, w_d;
  logic            op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NFLAG-1:0] s_q, s_d;
  logic [NFLAG-1:0] r_q, r_d;
  logic [NFLAG-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic            hit;
  logic [PW-1:0]   win;
  logic [IDXW-1:0] win_idx;
  int              k;

  // First asserted request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    hit = 1'b0;
    win = ptr_q;
    k   = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!hit && req[k]) begin
        hit = 1'b1;
        win = PW'(k);
      end
    end
  end

  assign win_idx = idx[int'(win)*IDXW +: IDXW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = hit ? PULSE : IDLE;
      PULSE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = '0;
    s_d    = '0;
    r_d    = '0;
    err_d  = 1'b0;
    busy_d = 1'b0;
    q_d    = q_q;
    ptr_d  = ptr_q;
    w_d    = w_q;
    op_d   = op_q;
    idx_d  = idx_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          w_d        = win;
          op_d       = op[win];
          idx_d      = win_idx;
          gnt_d[win] = 1'b1;
          busy_d     = 1'b1;
          if ({1'b0, win_idx} < NF) begin
            s_d[win_idx] = op[win];
            r_d[win_idx] = ~op[win];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PULSE: begin
        busy_d = 1'b1;
        if ({1'b0, idx_q} < NF) q_d[idx_q] = op_q;
        ptr_d = (int'(w_q) == NREQ-1) ? '0 : PW'(w_q + 1'b1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q  <= '0;
      s_q    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      ptr_q  <= '0;
      w_q    <= '0;
      op_q   <= 1'b0;
      idx_q  <= '0;
    end else begin
      gnt_q  <= gnt_d;
      s_q    <= s_d;
      r_q    <= r_d;
      q_q    <= q_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      ptr_q  <= ptr_d;
      w_q    <= w_d;
      op_q   <= op_d;
      idx_q  <= idx_d;
    end
  end

  assign gnt   = gnt_q;
  assign s_out = s_q;
  assign r_out = r_q;
  assign q     = q_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: vector table, multi-cycle corner sequences,
// and random operations against a transaction-level flag model.
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int IDXW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, op;
  logic [11:0]       idx;
  logic [NREQ-1:0]   gnt;
  logic [NFLAG-1:0]  s_out, r_out, q;
  logic              busy, err;

  int checks = 0;
  int errors = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .s_out(s_out), .r_out(r_out), .q(q),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  op;
    logic [11:0] idx;
    logic [3:0]  g;
    logic [5:0]  s;
    logic [5:0]  r;
    logic        e;
    logic [5:0]  q;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [11:0] pk(input logic [2:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sr_inv();
    chk("s_and_r", 32'(s_out & r_out), 0);
    chk("s_r_onehot", 32'($countones(s_out) + $countones(r_out) > 1), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic run_op(input int who, input logic o, input logic [2:0] ix);
    req = '0;
    req[who] = 1'b1;
    op[who] = o;
    idx[who*3 +: 3] = ix;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // random-phase model
  int         m_ptr;
  logic [5:0] m_flags;

  initial begin
    int g_who[$];
    int g_cyc[$];
    int cyc;
    int w;
    int n_ops;

    rst = 1'b1;
    req = 4'hF;
    op  = 4'hF;
    idx = 12'hFFF;

    tbl[0] = '{4'b0001, 4'b0001, pk(5,0,0,0), 4'b0001, 6'h20, 6'h00, 1'b0, 6'h20};
    tbl[1] = '{4'b0010, 4'b0010, pk(0,7,0,0), 4'b0010, 6'h00, 6'h00, 1'b1, 6'h20};
    tbl[2] = '{4'b1111, 4'b0000, pk(5,5,5,5), 4'b0100, 6'h00, 6'h20, 1'b0, 6'h00};
    tbl[3] = '{4'b1001, 4'b1111, pk(1,0,0,0), 4'b1000, 6'h01, 6'h00, 1'b0, 6'h01};
    tbl[4] = '{4'b1001, 4'b1111, pk(1,0,0,0), 4'b0001, 6'h02, 6'h00, 1'b0, 6'h03};
    tbl[5] = '{4'b0001, 4'b0001, pk(1,0,0,0), 4'b0001, 6'h02, 6'h00, 1'b0, 6'h03};
    tbl[6] = '{4'b0100, 4'b0000, pk(0,0,0,0), 4'b0100, 6'h00, 6'h01, 1'b0, 6'h02};
    tbl[7] = '{4'b0000, 4'b1111, pk(3,3,3,3), 4'b0000, 6'h00, 6'h00, 1'b0, 6'h02};
    tbl[8] = '{4'b0010, 4'b0000, pk(0,6,0,0), 4'b0010, 6'h00, 6'h00, 1'b1, 6'h02};

    // reset held with all requests asserted
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_s", 32'(s_out), 0);
      chk("rst_r", 32'(r_out), 0);
      chk("rst_q", 32'(q), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
    end
    req = '0;
    rst = 1'b0;
    @(negedge clk);

    // vector table
    foreach (tbl[i]) begin
      req = tbl[i].req;
      op  = tbl[i].op;
      idx = tbl[i].idx;
      @(negedge clk);
      req = '0;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
      chk($sformatf("v%0d_s", i), 32'(s_out), 32'(tbl[i].s));
      chk($sformatf("v%0d_r", i), 32'(r_out), 32'(tbl[i].r));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].e));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].g != 0));
      if (tbl[i].g != 0) begin
        @(negedge clk);
        chk($sformatf("v%0d_gap_busy", i), 32'(busy), 1);
        chk($sformatf("v%0d_gap_gnt", i), 32'(gnt | s_out | r_out), 0);
        chk($sformatf("v%0d_q", i), 32'(q), 32'(tbl[i].q));
        @(negedge clk);
        chk($sformatf("v%0d_idle_busy", i), 32'(busy), 0);
      end else begin
        chk($sformatf("v%0d_q", i), 32'(q), 32'(tbl[i].q));
      end
    end

    // contention: all request, each drops after its grant
    do_reset();
    req = 4'hF;
    op  = 4'b0101;
    idx = pk(0,1,2,3);
    cyc = 0;
    while (g_who.size() < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != 0) begin
        g_who.push_back(onehot_idx(gnt));
        g_cyc.push_back(cyc);
        req = req & ~gnt;
      end
    end
    chk("cont_count", 32'(g_who.size()), 4);
    for (int i = 0; i < g_who.size(); i++) begin
      chk($sformatf("cont_who%0d", i), 32'(g_who[i]), 32'(i));
      if (i > 0) chk($sformatf("cont_gap%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 3);
    end
    chk("cont_q", 32'(q), 32'(6'b000101));

    // fairness: requesters 0 and 2 held high
    do_reset();
    g_who.delete();
    req = 4'b0101;
    op  = 4'b0000;
    idx = pk(0,0,0,0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (gnt != 0) g_who.push_back(onehot_idx(gnt));
    end
    req = '0;
    chk("fair_count", 32'(g_who.size()), 8);
    for (int i = 0; i < g_who.size(); i++)
      chk($sformatf("fair_who%0d", i), 32'(g_who[i]), (i % 2 == 0) ? 0 : 2);
    @(negedge clk);
    @(negedge clk);

    // reset during a PULSE; requester 2 leaves ptr at 3
    do_reset();
    for (int f = 0; f < NFLAG; f++) run_op(2, 1'b1, 3'(f));
    chk("mid_fill_q", 32'(q), 32'h3F);
    req = 4'b1000;
    op  = 4'b0000;
    idx = pk(0,0,0,3);
    @(negedge clk);
    chk("mid_pulse_r", 32'(r_out), 32'h08);
    chk("mid_pulse_gnt", 32'(gnt), 32'b1000);
    rst = 1'b1;
    req = '0;
    #1;
    chk("mid_rst_r", 32'(r_out), 0);
    chk("mid_rst_q", 32'(q), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    @(negedge clk);
    req = '0;
    chk("mid_after_gnt", 32'(gnt), 32'b0010);
    @(negedge clk);
    @(negedge clk);

    // random operations against the flag model
    do_reset();
    m_ptr   = 0;
    m_flags = '0;
    n_ops   = 0;
    for (int t = 0; t < 300; t++) begin
      chk("rnd_idle_busy", 32'(busy), 0);
      chk("rnd_idle_gnt", 32'(gnt | s_out | r_out), 0);
      chk("rnd_idle_q", 32'(q), 32'(m_flags));
      req = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
      op  = 4'($urandom);
      idx = 12'($urandom);
      @(negedge clk);
      if (req == 0) continue;
      w = -1;
      for (int i = 0; i < NREQ; i++)
        if (w < 0 && req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
      begin
        int ix;
        logic o;
        logic [5:0] es;
        logic [5:0] er;
        ix = int'(idx[w*3 +: 3]);
        o  = op[w];
        es = '0;
        er = '0;
        if (ix < NFLAG) begin
          if (o) es[ix] = 1'b1;
          else   er[ix] = 1'b1;
        end
        chk("rnd_gnt", 32'(gnt), 32'(1 << w));
        chk("rnd_s", 32'(s_out), 32'(es));
        chk("rnd_r", 32'(r_out), 32'(er));
        chk("rnd_err", 32'(err), 32'(ix >= NFLAG));
        chk("rnd_busy", 32'(busy), 1);
        sr_inv();
        if (ix < NFLAG) m_flags[ix] = o;
        m_ptr = (w + 1) % NREQ;
      end
      req = 4'($urandom);
      op  = 4'($urandom);
      idx = 12'($urandom);
      @(negedge clk);
      chk("rnd_gap_busy", 32'(busy), 1);
      chk("rnd_gap_out", 32'(gnt | s_out | r_out), 0);
      chk("rnd_gap_err", 32'(err), 0);
      chk("rnd_gap_q", 32'(q), 32'(m_flags));
      req = '0;
      @(negedge clk);
      n_ops++;
    end
    chk("rnd_ops_seen", 32'(n_ops > 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
